// File: rtl/sync_down_timer.sv
// sync_down_timer: loadable down-counter with an IDLE/RUN/DONE controller.
// Optional feature macro: AUTO_RELOAD_EN. When it is defined, DONE re-arms
// from the reload register to give a periodic done pulse. When it is
// undefined, DONE lasts one cycle and the reload register does not exist.
//
// Controls (sampled on the rising clock edge, priority high to low):
//   rst   - synchronous reset to IDLE with count cleared
//   abort - return to IDLE with count held and no done pulse
//   start - load din (din==0 completes at once into DONE)
//   pause - hold count and state while in RUN
// state_o is a debug view of the controller: 0=IDLE, 1=RUN, 2=DONE.
module sync_down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // Next-state and next-count decision
  always_comb begin
    state_d = state_q;
    count_d = count_q;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (abort) begin
      state_d = IDLE;
    end else if (start) begin
      count_d = din;
`ifdef AUTO_RELOAD_EN
      reload_d = din;
`endif
      state_d = (din == '0) ? DONE : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (!pause) begin
            if (count_q <= WIDTH'(1)) begin
              count_d = '0;
              state_d = DONE;
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        DONE: begin
`ifdef AUTO_RELOAD_EN
          // The DONE cycle is the first cycle of the next period, so RUN
          // resumes at reload-1 and done repeats every reload cycles.
          // Reload values 0 and 1 keep done high every cycle.
          if (reload_q > WIDTH'(1)) begin
            count_d = reload_q - WIDTH'(1);
            state_d = RUN;
          end
`else
          state_d = IDLE;
`endif
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State, count and reload registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
`ifdef AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
`ifdef AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count   = count_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign state_o = state_q;

endmodule

// File: tb/tb_sync_down_timer.sv
// Testbench for sync_down_timer: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the timer kept in the bench.
module tb_sync_down_timer;

  localparam int WIDTH = 8;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             pause = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [1:0]       state_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model: mode, remaining count and reload value
  int m_mode = M_IDLE;
  int m_count = 0;
  int m_reload = 0;

  sync_down_timer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .pause(pause),
    .abort(abort), .count(count), .busy(busy), .done(done), .state_o(state_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Apply the timer's rules to the model for one rising edge
  task automatic model_step();
    if (rst) begin
      m_mode = M_IDLE; m_count = 0; m_reload = 0;
    end else if (abort) begin
      m_mode = M_IDLE;
    end else if (start) begin
      m_count = int'(din);
      m_reload = int'(din);
      m_mode = (din == 0) ? M_DONE : M_RUN;
    end else if (m_mode == M_RUN) begin
      if (!pause) begin
        m_count = m_count - 1;
        if (m_count == 0) m_mode = M_DONE;
      end
    end else if (m_mode == M_DONE) begin
`ifdef AUTO_RELOAD_EN
      if (m_reload >= 2) begin
        m_mode = M_RUN;
        m_count = m_reload - 1;
      end
`else
      m_mode = M_IDLE;
`endif
    end
  endtask

  // Advance one edge; outputs are stable 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; din = 8'd7; abort = 1'b0; pause = 1'b1;
    tick(); tick();
    tests_run++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || state_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset: count=%0d busy=%0b done=%0b state=%0d, want 0 0 0 0",
               count, busy, done, state_o);
    end
    idle_inputs();
    tick();
    tests_run++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: count=%0d busy=%0b done=%0b, want 0 0 0",
               count, busy, done);
    end
  endtask

  task automatic test_din3();
    int exp_cnt[5];
    logic exp_busy[5];
    logic exp_done[5];
    exp_cnt  = '{3, 2, 1, 0, 0};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    start = 1'b1; din = 8'd3;
    for (int e = 0; e < 5; e++) begin
      tick();
      start = 1'b0;
      tests_run++;
      if (count !== WIDTH'(exp_cnt[e]) || busy !== exp_busy[e] || done !== exp_done[e]) begin
        tests_failed++;
        $display("FAIL din3_edge%0d: count=%0d busy=%0b done=%0b, want %0d %0b %0b",
                 e, count, busy, done, exp_cnt[e], exp_busy[e], exp_done[e]);
      end
    end
  endtask

  task automatic test_din0();
    start = 1'b1; din = 8'd0;
    tick();
    start = 1'b0;
    tests_run++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL din0_done: count=%0d busy=%0b done=%0b, want 0 0 1", count, busy, done);
    end
    tick();
    tests_run++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || state_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL din0_after: count=%0d busy=%0b done=%0b state=%0d, want 0 0 0 0",
               count, busy, done, state_o);
    end
  endtask

  task automatic test_pause();
    int done_edge = -1;
    start = 1'b1; din = 8'd5;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 20 && done_edge < 0; e++) begin
      pause = (e == 3 || e == 4);
      tick();
      if (e == 4) begin
        tests_run++;
        if (count !== 8'd3 || busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL pause_hold: count=%0d busy=%0b, want 3 1", count, busy);
        end
      end
      if (done === 1'b1) done_edge = e;
    end
    pause = 1'b0;
    tests_run++;
    if (done_edge != 7) begin
      tests_failed++;
      $display("FAIL pause_latency: done at edge N+%0d, want N+7 (-1 = never)", done_edge);
    end
    tick();
  endtask

  task automatic test_abort_start();
    int pulses = 0;
    start = 1'b1; din = 8'd5;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    abort = 1'b1; start = 1'b1; din = 8'd9;
    tick();
    idle_inputs();
    tests_run++;
    if (count !== 8'd2 || busy !== 1'b0 || done !== 1'b0 || state_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL abort_start: count=%0d busy=%0b done=%0b state=%0d, want 2 0 0 0",
               count, busy, done, state_o);
    end
    for (int e = 0; e < 5; e++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 0 || count !== 8'd2) begin
      tests_failed++;
      $display("FAIL abort_quiet: done pulses=%0d count=%0d, want 0 2", pulses, count);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses = 0;
    start = 1'b1; din = 8'd6;
    tick();
    start = 1'b0;
    tick(); tick();
    tests_run++;
    if (count !== 8'd4) begin
      tests_failed++;
      $display("FAIL rst_run_setup: count=%0d, want 4", count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || state_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL rst_run: count=%0d busy=%0b done=%0b state=%0d, want 0 0 0 0",
               count, busy, done, state_o);
    end
    for (int e = 0; e < 8; e++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL rst_run_quiet: done pulses=%0d, want 0", pulses);
    end
  endtask

  task automatic test_done_pulses();
    int first = -1;
    int pulses = 0;
    int exp_pulses;
`ifdef AUTO_RELOAD_EN
    exp_pulses = 3;
`else
    exp_pulses = 1;
`endif
    start = 1'b1; din = 8'd4;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) first = e;
      end
    end
    tests_run++;
    if (first != 4 || pulses != exp_pulses) begin
      tests_failed++;
      $display("FAIL done_pulses: first at N+%0d, %0d pulses, want N+4 and %0d pulses",
               first, pulses, exp_pulses);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_pulses_abort: busy=%0b done=%0b, want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; din = 8'd7;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; pause = 1'b1; din = 8'd2;
    tick();
    idle_inputs();
    tests_run++;
    if (count !== 8'd2 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart: count=%0d busy=%0b, want 2 1", count, busy);
    end
    tick(); tick();
    tests_run++;
    if (count !== 8'd0 || done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_done: count=%0d busy=%0b done=%0b, want 0 0 1",
               count, busy, done);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      abort = ($urandom_range(0, 29) == 0);
      start = ($urandom_range(0, 7) == 0);
      pause = ($urandom_range(0, 4) == 0);
      din   = WIDTH'($urandom_range(0, 6));
      tick();
      tests_run++;
      if (count !== WIDTH'(m_count) || busy !== (m_mode == M_RUN) ||
          done !== (m_mode == M_DONE) || state_o !== 2'(m_mode)) begin
        tests_failed++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle%0d: count=%0d busy=%0b done=%0b state=%0d, want %0d %0b %0b %0d",
                   i, count, busy, done, state_o, m_count, m_mode == M_RUN,
                   m_mode == M_DONE, m_mode);
      end
    end
    idle_inputs();
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_din3();
    test_din0();
    test_pause();
    test_abort_start();
    test_reset_mid_run();
    test_done_pulses();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
